// File: rtl/coolgirl_bank_unit.sv
// rtl/coolgirl_bank_unit.sv - CoolGirl-style PRG/CHR bank mapper with optional CPU-cycle IRQ counter
//
// Purpose: decodes CPU writes into bank, base/mask and lock registers. It drives the
// flash PRG bank bits and the CHR bank bits for the current CPU and PPU addresses.
// An optional m2-cycle IRQ counter is compiled in when COOLGIRL_BANK_IRQ_EN is defined.
//
// Ports:
//   m2            clock; all state updates on the rising edge
//   reset         synchronous active-high reset
//   romsel        low = CPU $8000-$FFFF access
//   cpu_rw_in     high = read, low = write
//   cpu_addr_in   CPU A14..A0
//   cpu_data_in   CPU write data
//   ppu_addr_in   PPU A12..A0
//   cpu_bank_out  flash address bits above the PRG window offset
//   ppu_bank_out  CHR address bits above the CHR window offset
//   irq           active-high interrupt request (constant 0 without COOLGIRL_BANK_IRQ_EN)
module coolgirl_bank_unit #(
  parameter int PRG_SLOTS      = 4,
  parameter int CHR_SLOTS      = 8,
  parameter int BANK_W         = 8,
  parameter int IRQ_W          = 16,
  parameter int STARTUP_CYCLES = 255
) (
  input  logic              m2,
  input  logic              reset,
  input  logic              romsel,
  input  logic              cpu_rw_in,
  input  logic [14:0]       cpu_addr_in,
  input  logic [7:0]        cpu_data_in,
  input  logic [12:0]       ppu_addr_in,
  output logic [BANK_W-1:0] cpu_bank_out,
  output logic [BANK_W-1:0] ppu_bank_out,
  output logic              irq
);

  localparam int PRG_SEL_W = (PRG_SLOTS > 1) ? $clog2(PRG_SLOTS) : 1;
  localparam int CHR_SEL_W = (CHR_SLOTS > 1) ? $clog2(CHR_SLOTS) : 1;
  localparam int START_W   = (STARTUP_CYCLES > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;
  localparam logic [START_W-1:0] START_INIT = START_W'(STARTUP_CYCLES);

  logic [BANK_W-1:0]  prg_bank_q [PRG_SLOTS];
  logic [BANK_W-1:0]  prg_bank_d [PRG_SLOTS];
  logic [BANK_W-1:0]  chr_bank_q [CHR_SLOTS];
  logic [BANK_W-1:0]  chr_bank_d [CHR_SLOTS];
  logic [BANK_W-1:0]  prg_base_q, prg_base_d;
  logic [BANK_W-1:0]  prg_mask_q, prg_mask_d;
  logic [BANK_W-1:0]  chr_mask_q, chr_mask_d;
  logic               lock_q, lock_d;
  logic [START_W-1:0] startup_q, startup_d;

  logic [BANK_W-1:0]  data_bank;
  logic               wr_en;
  logic               cfg_sel;
  logic               bank_sel;
  logic [4:0]         bank_idx;
  logic [BANK_W-1:0]  prg_sel_bank;
  logic [BANK_W-1:0]  chr_sel_bank;
  logic               unused_inputs;

  // Size cast keeps the low BANK_W bits and zero-fills anything above bit 7.
  assign data_bank = BANK_W'(cpu_data_in);

  // Writes stay blind until the power-up settling counter has run out.
  assign wr_en    = ~cpu_rw_in & (startup_q == '0);
  assign cfg_sel  = romsel & (cpu_addr_in[14:12] == 3'b101);
  assign bank_sel = ~romsel & ~cpu_addr_in[14];
  assign bank_idx = {1'b0, cpu_addr_in[3:0]};

  // Only a handful of address bits are decoded; the rest are don't-care.
  assign unused_inputs = ^{cpu_addr_in, ppu_addr_in, cpu_data_in};

  generate
    if (PRG_SLOTS > 1) begin : g_prg_sel
      assign prg_sel_bank = prg_bank_q[cpu_addr_in[14 -: PRG_SEL_W]];
    end else begin : g_prg_one
      assign prg_sel_bank = prg_bank_q[0];
    end
    if (CHR_SLOTS > 1) begin : g_chr_sel
      assign chr_sel_bank = chr_bank_q[ppu_addr_in[12 -: CHR_SEL_W]];
    end else begin : g_chr_one
      assign chr_sel_bank = chr_bank_q[0];
    end
  endgenerate

  // Masked bank bits are replaced by the outer base so a game sees a smaller ROM.
  assign cpu_bank_out = prg_base_q | (prg_sel_bank & ~prg_mask_q);
  assign ppu_bank_out = chr_sel_bank & ~chr_mask_q;

  always_comb begin
    for (int i = 0; i < PRG_SLOTS; i++) prg_bank_d[i] = prg_bank_q[i];
    for (int i = 0; i < CHR_SLOTS; i++) chr_bank_d[i] = chr_bank_q[i];
    prg_base_d = prg_base_q;
    prg_mask_d = prg_mask_q;
    chr_mask_d = chr_mask_q;
    lock_d     = lock_q;
    startup_d  = (startup_q != '0) ? startup_q - START_W'(1) : startup_q;

    // Once locked, the outer configuration is frozen until the next reset.
    if (wr_en && cfg_sel && !lock_q) begin
      case (cpu_addr_in[1:0])
        2'd0:    prg_base_d = data_bank;
        2'd1:    prg_mask_d = data_bank;
        2'd2:    chr_mask_d = data_bank;
        default: lock_d     = cpu_data_in[7];
      endcase
    end

    // Register index A3..A0: PRG slots first, then CHR slots, rest ignored.
    if (wr_en && bank_sel) begin
      for (int i = 0; i < PRG_SLOTS; i++) begin
        if (bank_idx == 5'(i)) prg_bank_d[i] = data_bank;
      end
      for (int i = 0; i < CHR_SLOTS; i++) begin
        if (bank_idx == 5'(i + PRG_SLOTS)) chr_bank_d[i] = data_bank;
      end
    end
  end

  always_ff @(posedge m2) begin
    if (reset) begin
      for (int i = 0; i < PRG_SLOTS; i++) prg_bank_q[i] <= BANK_W'(i);
      for (int i = 0; i < CHR_SLOTS; i++) chr_bank_q[i] <= BANK_W'(i);
      prg_base_q <= '0;
      prg_mask_q <= '0;
      chr_mask_q <= '0;
      lock_q     <= 1'b0;
      startup_q  <= START_INIT;
    end else begin
      prg_bank_q <= prg_bank_d;
      chr_bank_q <= chr_bank_d;
      prg_base_q <= prg_base_d;
      prg_mask_q <= prg_mask_d;
      chr_mask_q <= chr_mask_d;
      lock_q     <= lock_d;
      startup_q  <= startup_d;
    end
  end

`ifdef COOLGIRL_BANK_IRQ_EN
  logic [IRQ_W-1:0] irq_cnt_q, irq_cnt_d;
  logic [IRQ_W-1:0] irq_latch_q, irq_latch_d;
  logic             irq_en_q, irq_en_d;
  logic             irq_q, irq_d;
  logic             irq_latch_wr;
  logic             irq_reload;
  logic             irq_ack;
  logic             irq_expire;

  assign irq_latch_wr = wr_en & ~romsel & (cpu_addr_in[14:13] == 2'b10) & ~cpu_addr_in[0];
  assign irq_reload   = wr_en & ~romsel & (cpu_addr_in[14:13] == 2'b10) &  cpu_addr_in[0];
  assign irq_ack      = wr_en & ~romsel & (cpu_addr_in[14:13] == 2'b11);

  always_comb begin
    irq_cnt_d   = irq_cnt_q;
    irq_latch_d = irq_latch_q;
    irq_en_d    = irq_en_q;
    irq_d       = irq_q;
    irq_expire  = 1'b0;

    // A reload write takes the counter for this edge; otherwise count while enabled.
    // Counter at 0 or 1 means this edge is the 1->0 step (or a zero latch), so fire and reload.
    if (irq_reload) begin
      irq_en_d  = cpu_data_in[0];
      irq_cnt_d = irq_latch_q;
    end else if (irq_en_q) begin
      if (irq_cnt_q <= IRQ_W'(1)) begin
        irq_expire = 1'b1;
        irq_cnt_d  = irq_latch_q;
      end else begin
        irq_cnt_d = irq_cnt_q - IRQ_W'(1);
      end
    end

    if (irq_latch_wr) irq_latch_d = IRQ_W'(cpu_data_in);

    // Expiry is applied after acknowledge so a coincident expiry is never lost.
    if (irq_ack)    irq_d = 1'b0;
    if (irq_expire) irq_d = 1'b1;
  end

  always_ff @(posedge m2) begin
    if (reset) begin
      irq_cnt_q   <= '0;
      irq_latch_q <= '0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      irq_cnt_q   <= irq_cnt_d;
      irq_latch_q <= irq_latch_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule
